// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// The result is computed at accept time and held until the fixed latency expires.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  mdop,
   input  logic        op_valid,
   input  logic        cancel,
   input  logic        rd_sel,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        md_stall
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;
   logic          r_busy;
   logic [CW-1:0] r_cnt;

   logic          w_is_md, w_accept;
   logic [CW-1:0] w_load;
   logic signed [63:0] w_prod_s;
   logic [63:0]   w_prod_u;
   logic [31:0]   w_quo_s, w_rem_s, w_quo_u, w_rem_u;
   logic          w_b_zero, w_div_ovf;
   logic [31:0]   w_res_hi, w_res_lo;

   assign w_is_md  = (mdop >= OP_MULT) && (mdop <= OP_DIVU);
   assign w_accept = op_valid && !cancel && !r_busy && (mdop >= OP_MULT) && (mdop <= OP_MTLO);
   assign w_load   = (mdop <= OP_MULTU) ? MULT_LOAD : DIV_LOAD;

   assign w_prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign w_prod_u  = {32'd0, a} * {32'd0, b};
   assign w_quo_s   = $signed(a) / $signed(b);
   assign w_rem_s   = $signed(a) % $signed(b);
   assign w_quo_u   = a / b;
   assign w_rem_u   = a % b;
   assign w_b_zero  = (b == 32'd0);
   assign w_div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

   // Divide-by-zero and the single signed overflow case are resolved explicitly
   always_comb begin
      w_res_hi = '0;
      w_res_lo = '0;
      case (mdop)
         OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
         OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
         OP_DIV: begin
            if (w_b_zero) begin
               w_res_hi = a;
               w_res_lo = 32'hFFFF_FFFF;
            end else if (w_div_ovf) begin
               w_res_hi = 32'd0;
               w_res_lo = 32'h8000_0000;
            end else begin
               w_res_hi = w_rem_s;
               w_res_lo = w_quo_s;
            end
         end
         OP_DIVU: begin
            if (w_b_zero) begin
               w_res_hi = a;
               w_res_lo = 32'hFFFF_FFFF;
            end else begin
               w_res_hi = w_rem_u;
               w_res_lo = w_quo_u;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi      <= '0;
         r_lo      <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_busy    <= 1'b0;
         r_cnt     <= '0;
      end else if (r_busy) begin
         // In-flight op ignores all new requests and commits on its last busy cycle
         r_cnt <= r_cnt - CW'(1);
         if (r_cnt == CW'(1)) begin
            r_hi   <= r_pend_hi;
            r_lo   <= r_pend_lo;
            r_busy <= 1'b0;
         end
      end else if (w_accept) begin
         case (mdop)
            OP_MTHI: r_hi <= a;
            OP_MTLO: r_lo <= a;
            default: begin
               r_pend_hi <= w_res_hi;
               r_pend_lo <= w_res_lo;
               r_busy    <= 1'b1;
               r_cnt     <= w_load;
            end
         endcase
      end
   end

   assign rd_data  = rd_sel ? r_hi : r_lo;
   assign busy     = r_busy;
   assign md_stall = r_busy || (op_valid && !cancel && w_is_md);

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a, b;
   logic [2:0]  mdop;
   logic        op_valid, cancel, rd_sel;
   logic [31:0] rd_data;
   logic        busy, md_stall;

   always #5 clk = ~clk;

   mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .mdop(mdop), .op_valid(op_valid),
      .cancel(cancel), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .md_stall(md_stall)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: architectural HI/LO, cycles left in flight, pending result
   logic [31:0] m_hi, m_lo;
   int          m_left;
   logic [63:0] m_pend;

   function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, sq, sr;
      longint unsigned ux, uy, uq, ur;
      logic [63:0] res;
      res = '0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (op)
         3'd1: res = sx * sy;
         3'd2: res = ux * uy;
         3'd3: begin
            if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
            else begin
               sq = sx / sy;
               sr = sx % sy;
               res = {sr[31:0], sq[31:0]};
            end
         end
         3'd4: begin
            if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
            else begin
               uq = ux / uy;
               ur = ux % uy;
               res = {ur[31:0], uq[31:0]};
            end
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   function automatic logic exp_stall();
      return (m_left > 0) || (op_valid && !cancel && mdop >= 3'd1 && mdop <= 3'd4);
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   task automatic model_edge();
      if (reset) begin
         m_hi = '0; m_lo = '0; m_left = 0; m_pend = '0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) {m_hi, m_lo} = m_pend;
      end else if (op_valid && !cancel && mdop >= 3'd1 && mdop <= 3'd6) begin
         if (mdop == 3'd5) m_hi = a;
         else if (mdop == 3'd6) m_lo = a;
         else begin
            m_pend = ref_md(mdop, a, b);
            m_left = (mdop <= 3'd2) ? MC : DC;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      rd_sel = 1'b0; #1; lo = rd_data;
      rd_sel = 1'b1; #1; hi = rd_data;
      rd_sel = 1'b0;
   endtask

   task automatic idle_inputs();
      op_valid = 1'b0; mdop = 3'd0; cancel = 1'b0; a = '0; b = '0;
   endtask

   // Issues one mult/div, waits for busy to drop; reports busy length and whether HI/LO held
   task automatic issue_and_wait(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb,
                                 output int n, output bit held, output bit timeout);
      logic [31:0] hi, lo;
      a = aa; b = bb; mdop = op; op_valid = 1'b1; cancel = 1'b0;
      $display("txn op=%0d a=%08h b=%08h", op, aa, bb);
      tick();
      idle_inputs();
      n = 0; held = 1'b1; timeout = 1'b0;
      while (busy === 1'b1) begin
         read_hilo(hi, lo);
         if (hi !== m_hi || lo !== m_lo) held = 1'b0;
         n++;
         tick();
         if (n > 50) begin timeout = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      logic [31:0] hi, lo;
      reset = 1'b1; idle_inputs(); rd_sel = 1'b0;
      tick(); tick();
      reset = 1'b0;
      read_hilo(hi, lo);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", md_stall); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%08h exp=00000000", lo); end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%08h exp=00000000", hi); end
   endtask

   task automatic test_mult();
      int n; bit held, to;
      logic [31:0] hi, lo;
      logic [63:0] exp;
      logic [2:0] op;
      logic [31:0] x, y;
      a = 32'hCAFE_0001; mdop = 3'd5; op_valid = 1'b1; tick();
      a = 32'hCAFE_0002; mdop = 3'd6; tick();
      idle_inputs();
      issue_and_wait(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, n, held, to);
      read_hilo(hi, lo);
      checks++; if (to || n != MC) begin errors++; $display("FAIL mult_busy_len got=%0d exp=%0d", n, MC); end
      checks++; if (!held) begin errors++; $display("FAIL mult_hold got=changed exp=held"); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%08h exp=FFFFFFFF", hi); end
      checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got=%08h exp=FFFFFFFE", lo); end
      issue_and_wait(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, n, held, to);
      read_hilo(hi, lo);
      checks++; if (to || n != MC || !held) begin errors++; $display("FAIL multu_timing len=%0d held=%0b exp len=%0d held=1", n, held, MC); end
      checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi got=%08h exp=00000001", hi); end
      checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got=%08h exp=FFFFFFFE", lo); end
      for (int i = 0; i < 6; i++) begin
         op = (i % 2 == 0) ? 3'd1 : 3'd2;
         x = rand_operand(); y = rand_operand();
         exp = ref_md(op, x, y);
         issue_and_wait(op, x, y, n, held, to);
         read_hilo(hi, lo);
         checks++; if ({hi, lo} !== exp || to) begin errors++; $display("FAIL mult_rand op=%0d got=%08h_%08h exp=%016h", op, hi, lo, exp); end
      end
   endtask

   task automatic test_div();
      int n; bit held, to;
      logic [31:0] hi, lo;
      logic [2:0] op;
      logic [31:0] x, y;
      logic [63:0] exp;
      issue_and_wait(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, n, held, to);
      read_hilo(hi, lo);
      checks++; if (to || n != DC || !held) begin errors++; $display("FAIL div_timing len=%0d held=%0b exp len=%0d held=1", n, held, DC); end
      checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg got hi=%08h lo=%08h exp hi=FFFFFFFF lo=FFFFFFFD", hi, lo); end
      issue_and_wait(3'd4, 32'h0000_0007, 32'h0000_0000, n, held, to);
      read_hilo(hi, lo);
      checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h0000_0007) begin errors++; $display("FAIL divu_zero got hi=%08h lo=%08h exp hi=00000007 lo=FFFFFFFF", hi, lo); end
      issue_and_wait(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n, held, to);
      read_hilo(hi, lo);
      checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0000_0000) begin errors++; $display("FAIL div_ovf got hi=%08h lo=%08h exp hi=00000000 lo=80000000", hi, lo); end
      issue_and_wait(3'd3, 32'h1234_5678, 32'h0000_0000, n, held, to);
      read_hilo(hi, lo);
      checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678) begin errors++; $display("FAIL div_zero got hi=%08h lo=%08h exp hi=12345678 lo=FFFFFFFF", hi, lo); end
      for (int i = 0; i < 6; i++) begin
         op = (i % 2 == 0) ? 3'd3 : 3'd4;
         x = rand_operand(); y = rand_operand();
         exp = ref_md(op, x, y);
         issue_and_wait(op, x, y, n, held, to);
         read_hilo(hi, lo);
         checks++; if ({hi, lo} !== exp || to) begin errors++; $display("FAIL div_rand op=%0d got=%08h_%08h exp=%016h", op, hi, lo, exp); end
      end
   endtask

   task automatic test_mthi_mtlo();
      logic [31:0] hi, lo, lo_before, hi_before;
      lo_before = m_lo; hi_before = m_hi;
      a = 32'h1234_5678; mdop = 3'd5; op_valid = 1'b1; cancel = 1'b0; rd_sel = 1'b1;
      $display("txn op=5 a=%08h", a);
      #1;
      checks++; if (rd_data !== hi_before) begin errors++; $display("FAIL mthi_no_bypass got=%08h exp=%08h", rd_data, hi_before); end
      checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL mthi_stall got=%b exp=0", md_stall); end
      tick();
      idle_inputs();
      read_hilo(hi, lo);
      checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got=%08h exp=12345678", hi); end
      checks++; if (lo !== lo_before) begin errors++; $display("FAIL mthi_lo_kept got=%08h exp=%08h", lo, lo_before); end
      a = 32'hDEAD_BEEF; mdop = 3'd6; op_valid = 1'b1; cancel = 1'b1;
      $display("txn op=6 a=%08h cancel=1", a);
      tick();
      idle_inputs();
      read_hilo(hi, lo);
      checks++; if (lo !== lo_before) begin errors++; $display("FAIL mtlo_cancel got=%08h exp=%08h", lo, lo_before); end
      a = 32'h0BAD_F00D; mdop = 3'd6; op_valid = 1'b1;
      $display("txn op=6 a=%08h", a);
      tick();
      idle_inputs();
      read_hilo(hi, lo);
      checks++; if (lo !== 32'h0BAD_F00D || hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo got hi=%08h lo=%08h exp hi=12345678 lo=0BADF00D", hi, lo); end
   endtask

   task automatic test_busy_ignore();
      int n;
      logic [31:0] hi, lo;
      a = 32'hFFFF_FC18; b = 32'd7; mdop = 3'd3; op_valid = 1'b1; cancel = 1'b0;
      $display("txn op=3 a=%08h b=%08h", a, b);
      tick();
      idle_inputs();
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         n++;
         if (n == 3) begin
            a = 32'h5555_5555; mdop = 3'd6; op_valid = 1'b1;
            $display("txn op=6 a=%08h (while busy)", a);
            #1;
            checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL busy_stall got=%b exp=1", md_stall); end
         end else begin
            idle_inputs();
         end
         tick();
      end
      idle_inputs();
      read_hilo(hi, lo);
      checks++; if (n != DC) begin errors++; $display("FAIL busy_ignore_len got=%0d exp=%0d", n, DC); end
      checks++; if (lo !== 32'hFFFF_FF72 || hi !== 32'hFFFF_FFFA) begin errors++; $display("FAIL busy_ignore_res got hi=%08h lo=%08h exp hi=FFFFFFFA lo=FFFFFF72", hi, lo); end
   endtask

   task automatic test_reset_during_busy();
      logic [31:0] hi, lo;
      a = 32'h1111_1111; mdop = 3'd5; op_valid = 1'b1; tick();
      a = 32'h2222_2222; mdop = 3'd6; tick();
      a = 32'd3; b = 32'd5; mdop = 3'd1;
      $display("txn op=1 a=%08h b=%08h then reset", a, b);
      tick();
      idle_inputs();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      read_hilo(hi, lo);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_busy got=%b exp=0", busy); end
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_busy_hilo got hi=%08h lo=%08h exp 0/0", hi, lo); end
      for (int i = 0; i < 6; i++) begin
         tick();
         read_hilo(hi, lo);
         checks++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_late_write cyc=%0d hi=%08h lo=%08h busy=%b exp 0/0/0", i, hi, lo, busy); end
      end
   endtask

   task automatic test_random();
      logic [31:0] hi, lo;
      for (int i = 0; i < 300; i++) begin
         reset    = ($urandom_range(0, 99) == 0);
         op_valid = ($urandom_range(0, 9) < 7);
         mdop     = 3'($urandom_range(0, 7));
         cancel   = ($urandom_range(0, 9) == 0);
         a        = rand_operand();
         b        = rand_operand();
         rd_sel   = 1'b0;
         #1;
         if (op_valid && !reset) $display("txn op=%0d a=%08h b=%08h cancel=%0b", mdop, a, b, cancel);
         checks++; if (md_stall !== exp_stall()) begin errors++; $display("FAIL rand_stall i=%0d got=%b exp=%b", i, md_stall, exp_stall()); end
         tick();
         reset = 1'b0;
         checks++; if (busy !== (m_left > 0)) begin errors++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, busy, (m_left > 0)); end
         read_hilo(hi, lo);
         checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL rand_hilo i=%0d got=%08h_%08h exp=%08h_%08h", i, hi, lo, m_hi, m_lo); end
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1; rd_sel = 1'b0;
      idle_inputs();
      m_hi = '0; m_lo = '0; m_left = 0; m_pend = '0;
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_busy_ignore();
      test_reset_during_busy();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
